// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// One operation in flight; the result is held in DONE until the consumer takes it or flush kills it.
module mdu_iterative #(
  parameter int BITSIZE = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [2:0]         operation_i,
  input  logic [BITSIZE-1:0] A_i,
  input  logic [BITSIZE-1:0] B_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [BITSIZE-1:0] R_o
);

  localparam int CW = $clog2(BITSIZE) + 1;
  localparam logic [CW-1:0]      CNT_LAST   = CW'(BITSIZE - 1);
  localparam logic [BITSIZE-1:0] MIN_SIGNED = {1'b1, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               op_q, op_d;
  logic                     neg_q, neg_d;
  logic [BITSIZE-1:0]       a_mag_q, a_mag_d;
  logic [BITSIZE-1:0]       b_mag_q, b_mag_d;
  logic [2*BITSIZE-1:0]     prod_q, prod_d;
  logic [BITSIZE-1:0]       quot_q, quot_d;
  logic [BITSIZE:0]         rem_q, rem_d;
  logic [BITSIZE-1:0]       r_q, r_d;

  logic                     a_signed, b_signed, a_neg, b_neg;
  logic [BITSIZE-1:0]       a_abs, b_abs;
  logic                     div_by_zero, div_ovf, special;
  logic [BITSIZE-1:0]       special_res;

  assign a_signed = (operation_i == 3'b001) || (operation_i == 3'b010) ||
                    (operation_i == 3'b100) || (operation_i == 3'b110);
  assign b_signed = (operation_i == 3'b001) || (operation_i == 3'b100) ||
                    (operation_i == 3'b110);
  assign a_neg    = a_signed && A_i[BITSIZE-1];
  assign b_neg    = b_signed && B_i[BITSIZE-1];
  assign a_abs    = a_neg ? -A_i : A_i;
  assign b_abs    = b_neg ? -B_i : B_i;

  // Divide corner cases bypass the iteration entirely.
  assign div_by_zero = (B_i == '0);
  assign div_ovf     = !operation_i[0] && (A_i == MIN_SIGNED) && (B_i == '1);
  assign special     = operation_i[2] && (div_by_zero || div_ovf);
  assign special_res = div_by_zero ? (operation_i[1] ? A_i : '1)
                                   : (operation_i[1] ? '0 : MIN_SIGNED);

  logic [BITSIZE:0]         mul_sum;
  logic [2*BITSIZE-1:0]     mul_step, mul_fix;
  logic [BITSIZE+1:0]       div_shift, div_diff;
  logic [BITSIZE-1:0]       quot_step;
  logic [BITSIZE:0]         rem_step;
  logic [BITSIZE-1:0]       res_calc;

  // Multiplier sits in the low half of prod and is shifted out as partial products accumulate.
  assign mul_sum   = {1'b0, prod_q[2*BITSIZE-1:BITSIZE]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
  assign mul_step  = {mul_sum, prod_q[BITSIZE-1:1]};
  assign mul_fix   = neg_q ? -mul_step : mul_step;

  assign div_shift = {rem_q, quot_q[BITSIZE-1]};
  assign div_diff  = div_shift - {2'b00, b_mag_q};
  assign quot_step = {quot_q[BITSIZE-2:0], ~div_diff[BITSIZE+1]};
  assign rem_step  = div_diff[BITSIZE+1] ? div_shift[BITSIZE:0] : div_diff[BITSIZE:0];

  always_comb begin
    res_calc = '0;
    if (!op_q[2]) begin
      res_calc = (op_q[1:0] == 2'b00) ? mul_fix[BITSIZE-1:0] : mul_fix[2*BITSIZE-1:BITSIZE];
    end else if (!op_q[1]) begin
      res_calc = neg_q ? -quot_step : quot_step;
    end else begin
      res_calc = neg_q ? -rem_step[BITSIZE-1:0] : rem_step[BITSIZE-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    prod_d  = prod_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          op_d    = operation_i;
          neg_d   = (operation_i[2] && operation_i[1]) ? a_neg : (a_neg ^ b_neg);
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          prod_d  = {{BITSIZE{1'b0}}, b_abs};
          quot_d  = a_abs;
          rem_d   = '0;
          cnt_d   = '0;
          if (special) begin
            r_d     = special_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (op_q[2]) begin
            quot_d = quot_step;
            rem_d  = rem_step;
          end else begin
            prod_d = mul_step;
          end
          cnt_d = cnt_q + CW'(1);
          // Final bit is folded into the sign-corrected result in the same cycle.
          if (cnt_q == CNT_LAST) begin
            r_d     = res_calc;
            state_d = DONE;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        if (flush_i || ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      prod_q  <= prod_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign R_o     = r_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed RV32M cases, randomized ops, backpressure, flush and reset aborts.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  operation_i = '0;
  logic [31:0] A_i = '0;
  logic [31:0] B_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] R_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mdu_iterative #(.BITSIZE(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .operation_i(operation_i), .A_i(A_i), .B_i(B_i), .valid_o(valid_o), .ready_i(ready_i),
    .R_o(R_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = '0;
    case (op)
      3'd0: t = ua * ub;
      3'd1: t = sa * sb;
      3'd2: t = sa * longint'(ub);
      3'd3: t = ua * ub;
      3'd4: if (b == 0) t = '1; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = {32'd0, a}; else t = sa / sb;
      3'd5: if (b == 0) t = '1; else t = ua / ub;
      3'd6: if (b == 0) t = {32'd0, a}; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = '0; else t = sa % sb;
      default: if (b == 0) t = {32'd0, a}; else t = ua % ub;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) return t[63:32];
    return t[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_i && !flush_i && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%h required=none", R_o);
      end else begin
        check("result", R_o, exp_q.pop_front());
      end
    end
  end

  // Present a request and return just after the edge that accepts it.
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_issue", {31'd0, ready_o}, 32'd1);
    operation_i = op; A_i = a; B_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    operation_i = 3'($urandom);
    A_i = $urandom;
    B_i = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    int lat;
    logic busy_err, stab_err;
    logic [31:0] r0;
    exp_q.push_back(ref_model(op, a, b));
    accept(op, a, b);
    lat = is_special(op, a, b) ? 1 : 33;
    busy_err = 1'b0;
    n = 1;  // the accepting edge counts as edge 1
    while (valid_o !== 1'b1 && n < 60) begin
      if (ready_o !== 1'b0) busy_err = 1'b1;
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("ready_low_while_busy", {31'd0, busy_err}, 32'd0);
    check("ready_low_in_done", {31'd0, ready_o}, 32'd0);
    r0 = R_o;
    stab_err = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (R_o !== r0 || valid_o !== 1'b1 || ready_o !== 1'b0) stab_err = 1'b1;
    end
    if (hold > 0) check("hold_stable", {31'd0, stab_err}, 32'd0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("idle_after_take", {30'd0, ready_o, valid_o}, 32'd2);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r_before;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready_o}, 32'd1);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_R", R_o, 32'd0);
    rst_i = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd0, 32'd12345, 32'd678, 10);
    run_op(3'd1, 32'hFFFF_FFF0, 32'd9, 2);

    // Flush mid-calculation: nothing emerges and R_o keeps the previous result.
    r_before = R_o;
    accept(3'd0, 32'd3, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_calc_idle", {30'd0, ready_o, valid_o}, 32'd2);
    check("flush_calc_R", R_o, r_before);
    begin
      logic rose = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (valid_o !== 1'b0) rose = 1'b1; end
      check("flush_no_valid", {31'd0, rose}, 32'd0);
    end

    // Flush in IDLE blocks acceptance.
    operation_i = 3'd0; A_i = 32'd1; B_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_no_accept", {31'd0, ready_o}, 32'd1);

    // Flush in DONE wins over ready_i.
    accept(3'd5, 32'd9, 32'd0);
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; ready_i = 1'b0;
    check("flush_done_idle", {30'd0, ready_o, valid_o}, 32'd2);
    check("flush_done_R", R_o, 32'hFFFF_FFFF);

    // Reset mid-calculation.
    accept(3'd4, 32'd1000, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_calc_outputs", {R_o[29:0], ready_o, valid_o}, 32'd2);
    check("rst_calc_R", R_o, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), int'($urandom_range(0, 3)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Execute issues operands and an M-extension funct3 over a valid/ready handshake and collects the result over a second valid/ready handshake.
- One operation in flight at a time. Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- BITSIZE, 32, operand/result width; counter width is clog2(BITSIZE)+1.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  pipeline kill; aborts any operation in flight.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request (high only in IDLE).
- operation_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A_i  input  BITSIZE  rs1 operand.
- B_i  input  BITSIZE  rs2 operand.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- R_o  output  BITSIZE  result, registered.

Behaviour:
- Reset: the reset value of every output is fixed.
  - state=IDLE; ready_o=1; valid_o=0; R_o=0; counter=0.
  - Reset in any state takes effect at the next edge and discards the operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o&&!flush_i, latch the operation and the operand magnitudes plus sign flags.
    - Signed operands: MULH A,B; MULHSU A only; DIV/REM A,B.
  - Next state is CALC, except for the special divide cases, which go directly to DONE with R_o loaded.
- Special divide cases:
  - B==0: DIV/DIVU give all-ones; REM/REMU give A.
  - DIV/REM with A==MIN_SIGNED and B==-1: DIV gives MIN_SIGNED; REM gives 0.
- CALC:
  - Runs exactly BITSIZE cycles, one partial product or one quotient bit per cycle, counter from 0 to BITSIZE-1.
  - Multiply uses a 2*BITSIZE product register.
  - Divide uses BITSIZE quotient and BITSIZE+1 remainder registers.
  - On the last cycle, apply sign correction and load R_o:
    - MUL: product[BITSIZE-1:0].
    - MULH/MULHSU/MULHU: product[2*BITSIZE-1:BITSIZE], after 2*BITSIZE-bit negation if the sign flags differ.
    - DIV: quotient, negated if sign(A)!=sign(B).
    - REM: remainder, negated if A was negative (remainder takes the sign of the dividend).
  - Then go to DONE.
- Latency: accepting edge E0.
  - Normal operations: valid_o high from edge E0+BITSIZE+1 (33 edges for BITSIZE=32).
  - Special divide cases: valid_o high from E0+1.
- DONE:
  - valid_o=1, ready_o=0.
  - R_o stays stable while valid_o&&!ready_i.
  - On ready_i, go to IDLE (valid_o=0, ready_o=1 the next cycle).
  - No back-to-back accept in DONE; the minimum issue interval is latency+1.
- flush_i:
  - In CALC or DONE, go to IDLE next edge; valid_o=0; R_o is not updated.
  - In IDLE, a simultaneous valid_i is not accepted.
  - flush_i has priority over ready_i.
- Operand changes on A_i/B_i/operation_i after acceptance have no effect.
- All arithmetic is modulo 2^BITSIZE on outputs; no overflow flag.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> R_o=0xFFFFFFEB.
  - valid_o rises exactly 33 edges after acceptance.
  - ready_o is 0 from acceptance until valid_o&&ready_i completes.
- MULH A=0x80000000, B=0x80000000 -> R_o=0x40000000.
  - Same operands with MULHU -> 0x40000000.
  - MULHSU A=-1, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> R_o=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
  - DIVU A=100, B=7 -> 14; REMU -> 2.
- Special cases, each completing in 1 cycle:
  - DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5.
  - DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o.
  - R_o and valid_o stay stable.
  - Pulse ready_i -> IDLE next cycle, and a new request is accepted.
- Abort cases:
  - Assert flush_i at CALC cycle 5 -> IDLE next edge; valid_o never rises; R_o is unchanged.
  - Assert rst_i mid-CALC -> all outputs return to reset values after the next edge.
